pll_mdrp_responder: RTL and testbench
=====================================

// Module: pll_mdrp_responder
// PURPOSE
//  Responder end of the PLL dynamic-reconfiguration (MDRP) port: accepts opcode/
//  address-increment/write-data traffic from a PLL init/config master, maintains
//  an 8-bit register bank, returns read data and models PLL lock re-acquisition.
//  Used as a fabric-side config target and as the bench partner for the init master.
// PARAMETERS
//  DEPTH       16   number of 8-bit registers; address range 0..DEPTH-1 (2..256)
//  LOCK_DELAY  64   mdclk cycles with no write before lock reasserts (>=1)
//  AW          8    address register width; DEPTH <= 2**AW
// PORTS
//  mdclk     in   1          sole clock; all logic on rising edge
//  reset     in   1          synchronous, active-high reset
//  mdopc     in   2          00 NOP, 01 WRITE, 10 READ, 11 reserved
//  mdainc    in   1          1 = increment address register this cycle
//  mdwdi     in   8          write data, sampled with mdopc=01
//  mdrdo     out  8          read data, registered
//  lock      out  1          modelled PLL lock
//  cfg_out   out  8*DEPTH    flat register bank, reg[i] at [8*i+7:8*i]
//  cfg_upd   out  1          one-cycle pulse after any accepted bank write
//  err       out  1          sticky: reserved opcode or write to status address
// BEHAVIOUR
//  Reset (reset=1 at edge): addr=0, all bank regs=8'h00, mdrdo=8'h00, lock=0,
//   cfg_upd=0, err=0, lock counter=0. Reset mid-operation aborts any op; no
//   partial write is retained.
//  Address: addr register only, never transmitted. mdainc=1 -> addr<=addr+1;
//   at addr==DEPTH-1 wraps to 0. Ops in the same cycle use the pre-increment addr.
//  WRITE (01): addr<DEPTH-1 -> reg[addr]<=mdwdi at that edge; cfg_out reflects it
//   the next cycle; cfg_upd=1 exactly the cycle after. addr==DEPTH-1 (status) ->
//   write dropped, err<=1, no cfg_upd.
//  READ (10): mdrdo<=reg[addr] at that edge (1-cycle latency); mdrdo holds value
//   until the next READ. Read of DEPTH-1 returns status {lock,err,6'b0}, using
//   values before that edge. Read-after-write same addr on consecutive cycles
//   returns new data.
//  NOP (00): no state change except addr increment and lock counter.
//  11: ignored apart from err<=1 and addr increment.
//  Lock model: states LOCKED / RELOCK. Out of reset: RELOCK, counter=0.
//   RELOCK: counter+1 each cycle without accepted write; counter==LOCK_DELAY-1
//   -> LOCKED, lock=1 next cycle. Accepted write in RELOCK -> counter<=0.
//   LOCKED: accepted write -> RELOCK, lock=0 next cycle, counter=0.
//   Dropped status writes do not affect lock.
//  err clears only on reset. Counter saturates; no wrap.
// TESTING
//  1 reset, LOCK_DELAY=64, only NOPs -> lock rises 64 cycles after reset release;
//    mdrdo=00, err=0.
//  2 WRITE 8'hA5 at addr0, ainc=1 same cycle, READ at addr1 -> cfg_out[7:0]=A5,
//    cfg_upd one pulse, mdrdo=00 (reg1); ainc back to 0 via wrap (DEPTH-1 incs), READ -> A5.
//  3 after lock, WRITE 8'h3C -> lock=0 next cycle; WRITE again 10 cycles later ->
//    lock returns 64 cycles after second write.
//  4 addr=DEPTH-1 WRITE 8'hFF -> bank unchanged, err=1, no cfg_upd; READ -> {lock,1,000000}.
//  5 mdopc=11 -> err=1, bank/mdrdo unchanged; assert reset mid-burst -> all outputs
//    at reset values next cycle, err=0.
//  6 WRITE 8'h5A then READ same addr next cycle -> mdrdo=5A one cycle after READ.

Source files
------------

// File: rtl/pll_mdrp_if.sv
// MDRP bus between a PLL config master and the responder.
// Opcode, address-increment and write data go out; read data comes back.
interface pll_mdrp_if;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;

  modport master (
    output mdopc,
    output mdainc,
    output mdwdi,
    input  mdrdo
  );

  modport slave (
    input  mdopc,
    input  mdainc,
    input  mdwdi,
    output mdrdo
  );
endinterface

// File: rtl/pll_mdrp_responder.sv
// MDRP responder: 8-bit register bank, registered read-back and a
// PLL lock model that drops on each accepted write and relocks later.
module pll_mdrp_responder #(
  parameter int DEPTH      = 16,
  parameter int LOCK_DELAY = 64,
  parameter int AW         = 8
) (
  input  logic               mdclk,
  input  logic               reset,
  pll_mdrp_if.slave          bus,
  output logic               lock,
  output logic [8*DEPTH-1:0] cfg_out,
  output logic               cfg_upd,
  output logic               err
);

  localparam int CW = $clog2(LOCK_DELAY + 1);
  localparam logic [AW-1:0] TOP  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(LOCK_DELAY - 1);

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_WR  = 2'b01,
    OP_RD  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic {
    RELOCK,
    LOCKED
  } lock_e;

  logic [AW-1:0] addr;
  logic [7:0]    bank [DEPTH];
  lock_e         state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          is_top;
  logic          is_wr;
  logic          is_rd;
  logic          wr_ok;
  logic          bad;
  logic [7:0]    rd_val;

  assign is_top = (addr == TOP);
  assign is_wr  = (bus.mdopc == OP_WR);
  assign is_rd  = (bus.mdopc == OP_RD);
  assign wr_ok  = is_wr && !is_top;
  assign bad    = (bus.mdopc == OP_RSV) || (is_wr && is_top);
  assign lock   = (state == LOCKED);

  // top address is the status byte, not a bank entry
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) rd_val = bank[i];
    end
    if (is_top) rd_val = {lock, err, 6'b0};
  end

  always_ff @(posedge mdclk) begin
    if (reset) begin
      addr      <= '0;
      bus.mdrdo <= '0;
      cfg_upd   <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      if (bus.mdainc) addr <= is_top ? '0 : addr + AW'(1);
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (wr_ok && addr == AW'(i)) bank[i] <= bus.mdwdi;
      end
      if (is_rd) bus.mdrdo <= rd_val;
      cfg_upd <= wr_ok;
      if (bad) err <= 1'b1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cfg
    assign cfg_out[8*g +: 8] = bank[g];
  end

  always_ff @(posedge mdclk) begin
    if (reset) begin
      state <= RELOCK;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // counter parks at CMAX once locked
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      RELOCK: begin
        if (wr_ok) cnt_n = '0;
        else if (cnt == CMAX) state_n = LOCKED;
        else cnt_n = cnt + CW'(1);
      end
      LOCKED: begin
        if (wr_ok) begin
          state_n = RELOCK;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = RELOCK;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_mdrp_responder.sv
// Directed bench for pll_mdrp_responder: reset, write/read,
// lock re-acquisition, status address, reserved opcode, mid-op reset.
module tb_pll_mdrp_responder;

  localparam int DEPTH = 16;
  localparam int LD    = 64;

  logic mdclk = 1'b0;
  logic reset = 1'b1;
  logic lock;
  logic [8*DEPTH-1:0] cfg_out;
  logic cfg_upd;
  logic err;

  int checks   = 0;
  int failures = 0;

  pll_mdrp_if bus ();

  pll_mdrp_responder #(
    .DEPTH(DEPTH),
    .LOCK_DELAY(LD),
    .AW(8)
  ) dut (
    .mdclk(mdclk),
    .reset(reset),
    .bus(bus),
    .lock(lock),
    .cfg_out(cfg_out),
    .cfg_upd(cfg_upd),
    .err(err)
  );

  always #5 mdclk = ~mdclk;

  task automatic tick();
    @(posedge mdclk);
    #1;
  endtask

  task automatic drive(input logic [1:0] opc, input logic ainc,
                       input logic [7:0] wdi);
    bus.mdopc  = opc;
    bus.mdainc = ainc;
    bus.mdwdi  = wdi;
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    drive(2'b00, 1'b0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (lock) break;
    end
  endtask

  task automatic nop_incs(input int k);
    for (int i = 0; i < k; i++) begin
      drive(2'b00, 1'b1, 8'h00);
      tick();
    end
    drive(2'b00, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    drive(2'b00, 1'b0, 8'h00);
    tick();
    tick();
    checks++;
    if (lock !== 1'b0) begin
      failures++;
      $display("FAIL reset_lock got=%b exp=0", lock);
    end
    checks++;
    if (bus.mdrdo !== 8'h00) begin
      failures++;
      $display("FAIL reset_rdo got=%h exp=00", bus.mdrdo);
    end
    checks++;
    if (err !== 1'b0 || cfg_upd !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags err=%b upd=%b exp=0,0", err, cfg_upd);
    end
    checks++;
    if (cfg_out !== '0) begin
      failures++;
      $display("FAIL reset_bank got=%h exp=0", cfg_out);
    end
    reset = 1'b0;
    wait_lock(n);
    checks++;
    if (n !== LD || lock !== 1'b1) begin
      failures++;
      $display("FAIL lock_rise cycles=%0d lock=%b exp=%0d,1", n, lock, LD);
    end
    checks++;
    if (bus.mdrdo !== 8'h00 || err !== 1'b0) begin
      failures++;
      $display("FAIL nop_idle rdo=%h err=%b exp=00,0", bus.mdrdo, err);
    end
  endtask

  task automatic test_write_read();
    drive(2'b01, 1'b1, 8'hA5);
    tick();
    checks++;
    if (cfg_out[7:0] !== 8'hA5 || cfg_upd !== 1'b1) begin
      failures++;
      $display("FAIL wr_a5 reg0=%h upd=%b exp=a5,1", cfg_out[7:0], cfg_upd);
    end
    checks++;
    if (lock !== 1'b0) begin
      failures++;
      $display("FAIL wr_unlock got=%b exp=0", lock);
    end
    drive(2'b10, 1'b0, 8'h00);
    tick();
    checks++;
    if (bus.mdrdo !== 8'h00 || cfg_upd !== 1'b0) begin
      failures++;
      $display("FAIL rd_reg1 rdo=%h upd=%b exp=00,0", bus.mdrdo, cfg_upd);
    end
    nop_incs(DEPTH - 1);
    drive(2'b10, 1'b0, 8'h00);
    tick();
    checks++;
    if (bus.mdrdo !== 8'hA5) begin
      failures++;
      $display("FAIL rd_wrap got=%h exp=a5", bus.mdrdo);
    end
  endtask

  task automatic test_relock();
    int n;
    wait_lock(n);
    checks++;
    if (lock !== 1'b1) begin
      failures++;
      $display("FAIL pre_lock got=%b exp=1", lock);
    end
    drive(2'b01, 1'b0, 8'h3C);
    tick();
    checks++;
    if (lock !== 1'b0 || cfg_out[7:0] !== 8'h3C) begin
      failures++;
      $display("FAIL wr_3c lock=%b reg0=%h exp=0,3c", lock, cfg_out[7:0]);
    end
    drive(2'b00, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) tick();
    drive(2'b01, 1'b0, 8'h77);
    tick();
    checks++;
    if (lock !== 1'b0 || cfg_out[7:0] !== 8'h77) begin
      failures++;
      $display("FAIL wr_77 lock=%b reg0=%h exp=0,77", lock, cfg_out[7:0]);
    end
    wait_lock(n);
    checks++;
    if (n !== LD || lock !== 1'b1) begin
      failures++;
      $display("FAIL relock cycles=%0d lock=%b exp=%0d,1", n, lock, LD);
    end
  endtask

  task automatic test_status();
    logic [8*DEPTH-1:0] exp;
    exp = '0;
    exp[7:0] = 8'h77;
    nop_incs(DEPTH - 1);
    drive(2'b01, 1'b0, 8'hFF);
    tick();
    checks++;
    if (cfg_out !== exp || cfg_upd !== 1'b0) begin
      failures++;
      $display("FAIL st_wr bank=%h upd=%b exp=%h,0", cfg_out, cfg_upd, exp);
    end
    checks++;
    if (err !== 1'b1 || lock !== 1'b1) begin
      failures++;
      $display("FAIL st_err err=%b lock=%b exp=1,1", err, lock);
    end
    drive(2'b10, 1'b0, 8'h00);
    tick();
    checks++;
    if (bus.mdrdo !== 8'hC0) begin
      failures++;
      $display("FAIL st_rd got=%h exp=c0", bus.mdrdo);
    end
    nop_incs(1);
  endtask

  task automatic test_reserved_reset();
    logic [8*DEPTH-1:0] exp;
    reset = 1'b1;
    drive(2'b00, 1'b0, 8'h00);
    tick();
    reset = 1'b0;
    drive(2'b01, 1'b0, 8'h12);
    tick();
    drive(2'b10, 1'b0, 8'h00);
    tick();
    exp = '0;
    exp[7:0] = 8'h12;
    drive(2'b11, 1'b0, 8'hEE);
    tick();
    checks++;
    if (err !== 1'b1 || bus.mdrdo !== 8'h12) begin
      failures++;
      $display("FAIL rsv err=%b rdo=%h exp=1,12", err, bus.mdrdo);
    end
    checks++;
    if (cfg_out !== exp || cfg_upd !== 1'b0) begin
      failures++;
      $display("FAIL rsv_bank bank=%h upd=%b exp=%h,0", cfg_out, cfg_upd, exp);
    end
    drive(2'b01, 1'b1, 8'h99);
    reset = 1'b1;
    tick();
    checks++;
    if (cfg_out !== '0 || bus.mdrdo !== 8'h00 || err !== 1'b0 ||
        lock !== 1'b0 || cfg_upd !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst bank=%h rdo=%h err=%b lock=%b upd=%b exp=0",
               cfg_out, bus.mdrdo, err, lock, cfg_upd);
    end
    reset = 1'b0;
    drive(2'b00, 1'b0, 8'h00);
    tick();
    checks++;
    if (cfg_upd !== 1'b0 || cfg_out !== '0) begin
      failures++;
      $display("FAIL post_rst upd=%b bank=%h exp=0,0", cfg_upd, cfg_out);
    end
  endtask

  task automatic test_raw();
    drive(2'b01, 1'b0, 8'h5A);
    tick();
    drive(2'b10, 1'b0, 8'h00);
    tick();
    checks++;
    if (bus.mdrdo !== 8'h5A) begin
      failures++;
      $display("FAIL raw got=%h exp=5a", bus.mdrdo);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [3];
    d[0] = 8'h11;
    d[1] = 8'h22;
    d[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1'b1, d[i]);
      tick();
      checks++;
      if (cfg_upd !== 1'b1 || cfg_out[8*i +: 8] !== d[i]) begin
        failures++;
        $display("FAIL b2b_wr%0d upd=%b reg=%h exp=1,%h",
                 i, cfg_upd, cfg_out[8*i +: 8], d[i]);
      end
    end
    nop_incs(DEPTH - 3);
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 1'b1, 8'h00);
      tick();
      checks++;
      if (bus.mdrdo !== d[i]) begin
        failures++;
        $display("FAIL b2b_rd%0d got=%h exp=%h", i, bus.mdrdo, d[i]);
      end
    end
    drive(2'b00, 1'b0, 8'h00);
  endtask

  initial begin
    drive(2'b00, 1'b0, 8'h00);
    test_reset();
    test_write_read();
    test_relock();
    test_status();
    test_reserved_reset();
    test_raw();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
